floor_request_latch: RTL

Upstream stage of the 5-floor elevator controller. It converts raw call-button levels into sticky per-floor requests that drive the controller's `ra`..`re` inputs, and it runs the door cycle at the current floor. A request stays asserted while the car is parked and the door is open, so the controller holds position. The request clears only when the door closes, which releases the controller to move to the next target.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/floor_request_latch_if.sv | 30 +++
 rtl/door_timer.sv | 37 +++
 rtl/floor_request_latch.sv | 119 +++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator floor-request front end.
package elevator_pkg;

  localparam int NUM_FLOORS = 5;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    DOOR_IDLE  = 2'd0,
    DOOR_OPEN  = 2'd1,
    DOOR_CLOSE = 2'd2
  } door_state_e;

  localparam logic [FLOOR_W-1:0] FLOOR_A = 3'd0;
  localparam logic [FLOOR_W-1:0] FLOOR_B = 3'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_C = 3'd2;
  localparam logic [FLOOR_W-1:0] FLOOR_D = 3'd3;
  localparam logic [FLOOR_W-1:0] FLOOR_E = 3'd4;

endpackage

// File: rtl/floor_request_latch_if.sv
// Button/floor inputs and request/door status outputs of the request latch.
interface floor_request_latch_if #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
);
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] btn;
  logic [FLOOR_W-1:0]    floor;
  logic [NUM_FLOORS-1:0] req;
  logic                  door_open;
  logic                  busy;

  modport master (
    output btn,
    output floor,
    input  req,
    input  door_open,
    input  busy
  );

  modport slave (
    input  btn,
    input  floor,
    output req,
    output door_open,
    output busy
  );

endinterface

// File: rtl/door_timer.sv
// Door-open down-counter: load to DOOR_CYCLES-1, count down to zero and hold.
module door_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(DOOR_CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/floor_request_latch.sv
// Sticky per-floor call requests plus the door open/close cycle at the
// current floor.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | door shut, waiting for a request at the current floor
//   ST_OPEN    | door open, timer running; request at this floor held
//   ST_CLOSE   | one guard cycle after the door drops, then back to IDLE
module floor_request_latch #(
  parameter int NUM_FLOORS  = elevator_pkg::NUM_FLOORS,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  floor_request_latch_if.slave  bus
);
  import elevator_pkg::*;

  localparam logic [1:0] ST_IDLE  = DOOR_IDLE;
  localparam logic [1:0] ST_OPEN  = DOOR_OPEN;
  localparam logic [1:0] ST_CLOSE = DOOR_CLOSE;

  logic [NUM_FLOORS-1:0] btn_q;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  req_here;
  logic                  rise_here;
  logic                  tmr_load, tmr_en, tmr_zero;

  // Rising-edge detect; btn_q resets high so a button held through reset is ignored.
  always_comb begin
    rise = bus.btn & ~btn_q;
  end

  // Per-floor lookups; an out-of-range floor index matches nothing.
  always_comb begin
    req_here  = 1'b0;
    rise_here = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bus.floor == FLOOR_W'(i)) req_here  = req_q[i];
      if (floor_q   == FLOOR_W'(i)) rise_here = rise[i];
    end
  end

  // Door FSM next state. At timer zero the door always closes; a press on
  // that same edge is kept by the request register, which reopens the door.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_here) begin
          state_d  = ST_OPEN;
          floor_d  = bus.floor;
          tmr_load = 1'b1;
        end
      end
      ST_OPEN: begin
        if (tmr_zero) begin
          state_d = ST_CLOSE;
          for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_q == FLOOR_W'(i)) clr_mask[i] = 1'b1;
          end
        end else if (rise_here) begin
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_CLOSE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear from the door cycle first, then set from new presses so set wins.
  always_comb begin
    req_d = (req_q & ~clr_mask) | rise;
  end

  // State, request and button-history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q   <= '1;
      req_q   <= '0;
      state_q <= ST_IDLE;
      floor_q <= '0;
    end else begin
      btn_q   <= bus.btn;
      req_q   <= req_d;
      state_q <= state_d;
      floor_q <= floor_d;
    end
  end

  door_timer #(
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .zero (tmr_zero)
  );

  assign bus.req       = req_q;
  assign bus.door_open = (state_q == ST_OPEN);
  assign bus.busy      = (|req_q) || (state_q != ST_IDLE);

endmodule
